// File: rtl/ccff_chain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ccff_chain_ctrl_pkg
// Brief   : Shared FSM state and command-mode encodings for the CCFF chain
//           controller.
// Revision: 1.0
// ============================================================================
package ccff_chain_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_P_FETCH = 3'd1,
      ST_P_SHIFT = 3'd2,
      ST_R_SHIFT = 3'd3,
      ST_R_PUSH  = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   localparam logic CMD_PROG = 1'b0;
   localparam logic CMD_RD   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ccff_shift_word.sv
`default_nettype none
// ============================================================================
// Module  : ccff_shift_word
// Brief   : Word shift register (parallel load, serial in at LSB, serial out
//           at MSB) with a word-bit counter and last-bit flag.
// Revision: 1.0
// ============================================================================
module ccff_shift_word #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_load_data,
   input  logic              i_shift,
   input  logic              i_ser_in,
   output logic [WORD_W-1:0] o_word,
   output logic              o_ser_out,
   output logic              o_last
);

   localparam int               BIT_W    = $clog2(WORD_W);
   localparam logic [BIT_W-1:0] C_LAST   = BIT_W'(WORD_W - 1);

   logic [WORD_W-1:0] r_sreg_q, w_sreg_d;
   logic [BIT_W-1:0]  r_bit_q,  w_bit_d;

   always_comb begin
      w_sreg_d = r_sreg_q;
      w_bit_d  = r_bit_q;
      if (i_clear) begin
         w_sreg_d = '0;
         w_bit_d  = '0;
      end else if (i_load) begin
         w_sreg_d = i_load_data;
         w_bit_d  = '0;
      end else if (i_shift) begin
         w_sreg_d = {r_sreg_q[WORD_W-2:0], i_ser_in};
         w_bit_d  = (r_bit_q == C_LAST) ? '0 : r_bit_q + BIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg_q <= '0;
         r_bit_q  <= '0;
      end else begin
         r_sreg_q <= w_sreg_d;
         r_bit_q  <= w_bit_d;
      end
   end

   assign o_word    = r_sreg_q;
   assign o_ser_out = r_sreg_q[WORD_W-1];
   assign o_last    = (r_bit_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ccff_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ccff_chain_ctrl
// Brief   : Word-level program/readback controller for the CCFF scan chain.
// Revision: 1.0
// ============================================================================
module ccff_chain_ctrl
   import ccff_chain_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN = 1024,
   parameter int WORD_W    = 32
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rd,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_en,
   output logic              busy,
   output logic              done
);

   localparam int               CNT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] C_LEN = CNT_W'(CHAIN_LEN);

   state_e           r_state_q, w_state_d;
   logic [CNT_W-1:0] r_bit_cnt_q, w_bit_cnt_d, w_bit_cnt_inc;

   logic              w_sw_clear, w_sw_load, w_sw_shift, w_sw_ser_in;
   logic              w_sw_last, w_sw_ser_out;
   logic [WORD_W-1:0] w_sw_word;

   assign w_bit_cnt_inc = r_bit_cnt_q + CNT_W'(1);

   always_comb begin
      w_state_d   = r_state_q;
      w_bit_cnt_d = r_bit_cnt_q;
      w_sw_clear  = 1'b0;
      w_sw_load   = 1'b0;
      w_sw_shift  = 1'b0;
      w_sw_ser_in = 1'b0;
      case (r_state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_bit_cnt_d = '0;
               w_sw_clear  = 1'b1;
               w_state_d   = (cmd_rd == CMD_RD) ? ST_R_SHIFT : ST_P_FETCH;
            end
         end
         ST_P_FETCH: begin
            if (wr_valid) begin
               w_sw_load = 1'b1;
               w_state_d = ST_P_SHIFT;
            end
         end
         ST_P_SHIFT: begin
            // Low bits of a final partial word never leave the register.
            w_sw_shift  = 1'b1;
            w_bit_cnt_d = w_bit_cnt_inc;
            if (w_bit_cnt_inc == C_LEN) begin
               w_state_d = ST_DONE;
            end else if (w_sw_last) begin
               w_state_d = ST_P_FETCH;
            end
         end
         ST_R_SHIFT: begin
            w_sw_shift  = 1'b1;
            w_sw_ser_in = ccff_tail;
            w_bit_cnt_d = w_bit_cnt_inc;
            if ((w_bit_cnt_inc == C_LEN) || w_sw_last) begin
               w_state_d = ST_R_PUSH;
            end
         end
         ST_R_PUSH: begin
            if (rd_ready) begin
               w_sw_clear = 1'b1;
               w_state_d  = (r_bit_cnt_q == C_LEN) ? ST_DONE : ST_R_SHIFT;
            end
         end
         ST_DONE: w_state_d = ST_IDLE;
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_state_q   <= ST_IDLE;
         r_bit_cnt_q <= '0;
      end else begin
         r_state_q   <= w_state_d;
         r_bit_cnt_q <= w_bit_cnt_d;
      end
   end

   ccff_shift_word #(
      .WORD_W (WORD_W)
   ) u_shift_word (
      .clk         (prog_clk),
      .rst_n       (pReset_n),
      .i_clear     (w_sw_clear),
      .i_load      (w_sw_load),
      .i_load_data (wr_data),
      .i_shift     (w_sw_shift),
      .i_ser_in    (w_sw_ser_in),
      .o_word      (w_sw_word),
      .o_ser_out   (w_sw_ser_out),
      .o_last      (w_sw_last)
   );

   // All outputs decode from reset-cleared state, so reset reaches them at once.
   assign cmd_ready = (r_state_q == ST_IDLE);
   assign busy      = (r_state_q != ST_IDLE);
   assign done      = (r_state_q == ST_DONE);
   assign wr_ready  = (r_state_q == ST_P_FETCH);
   assign rd_valid  = (r_state_q == ST_R_PUSH);
   assign rd_data   = (r_state_q == ST_R_PUSH) ? w_sw_word : '0;
   assign chain_en  = (r_state_q == ST_P_SHIFT) || (r_state_q == ST_R_SHIFT);
   assign ccff_head = (r_state_q == ST_P_SHIFT) ? w_sw_ser_out :
                      (r_state_q == ST_R_SHIFT) ? ccff_tail    : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ccff_chain_ctrl
// Brief   : Scoreboard bench for ccff_chain_ctrl with behavioural chain models
//           (40-bit / 16-bit words, plus a 1-bit chain instance).
// Revision: 1.0
// ============================================================================
module tb_ccff_chain_ctrl;

   localparam int LEN = 40;
   localparam int W   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic         cmd_valid, cmd_ready, cmd_rd, wr_valid, wr_ready;
   logic [W-1:0] wr_data, rd_data;
   logic         rd_valid, rd_ready, head, tail, chain_en, busy, done;

   logic         cmd_valid1, cmd_ready1, cmd_rd1, wr_valid1, wr_ready1;
   logic [W-1:0] wr_data1, rd_data1;
   logic         rd_valid1, rd_ready1, head1, tail1, chain_en1, busy1, done1;

   logic [LEN-1:0] chain;
   logic           chain1;
   assign tail  = chain[LEN-1];
   assign tail1 = chain1;

   ccff_chain_ctrl #(.CHAIN_LEN(LEN), .WORD_W(W)) u_dut (
      .prog_clk(clk), .pReset_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rd(cmd_rd), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .ccff_head(head),
      .ccff_tail(tail), .chain_en(chain_en), .busy(busy), .done(done));

   ccff_chain_ctrl #(.CHAIN_LEN(1), .WORD_W(W)) u_dut1 (
      .prog_clk(clk), .pReset_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_rd(cmd_rd1), .wr_data(wr_data1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready1), .ccff_head(head1),
      .ccff_tail(tail1), .chain_en(chain_en1), .busy(busy1), .done(done1));

   int en_cnt, wr_cnt, done_cnt, en1_cnt, done1_cnt;
   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp1_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Chain models: first bit shifted in ends up at the tail.
   always @(posedge clk) begin
      if (chain_en) begin
         chain  <= {chain[LEN-2:0], head};
         en_cnt <= en_cnt + 1;
      end
      if (wr_valid && wr_ready) wr_cnt <= wr_cnt + 1;
      if (chain_en1) begin
         chain1  <= head1;
         en1_cnt <= en1_cnt + 1;
      end
   end

   logic [W-1:0] held;
   logic         prev_stall = 1'b0;

   always @(negedge clk) begin
      if (done)  done_cnt++;
      if (done1) done1_cnt++;
      if (rd_valid && rd_ready) begin
         if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
         else check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
      if (prev_stall && rd_valid) check("rd_stable", 64'(rd_data), 64'(held));
      prev_stall = rd_valid && !rd_ready;
      held       = rd_data;
      if (busy) check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (busy && !chain_en) check("head_idle", 64'(head), 64'd0);
      if (wr_ready || rd_valid) check("no_shift_stall", 64'(chain_en), 64'd0);
      if (rd_valid1 && rd_ready1) begin
         if (exp1_q.size() == 0) check("rd1_unexpected", 64'd1, 64'd0);
         else check("rd1_data", 64'(rd_data1), 64'(exp1_q.pop_front()));
      end
   end

   task automatic start_cmd(input logic rd, input bit hold);
      bit ok = 1'b0;
      cmd_rd    = rd;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk); #1;
      end
      if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input bit throttle);
      logic [W-1:0] w[3];
      int idx = 0;
      bit x;
      w[0] = a; w[1] = b; w[2] = c;
      for (int cyc = 0; cyc < 2000 && idx < 3; cyc++) begin
         wr_data  = w[idx];
         wr_valid = !throttle || (cyc % 3 == 0);
         @(negedge clk);
         x = wr_valid && wr_ready;
         @(posedge clk); #1;
         if (x) idx++;
      end
      wr_valid = 1'b0;
      if (idx != 3) check("wr_timeout", 64'(idx), 64'd3);
   endtask

   task automatic wait_done;
      bit seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic readback(input int stall);
      bit fin = 1'b0;
      int sc  = 0;
      bit nv;
      rd_ready = (stall == 0);
      start_cmd(1'b1, 1'b0);
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(negedge clk);
         if (done) fin = 1'b1;
         else begin
            if (rd_valid && rd_ready) begin sc = 0; nv = (stall == 0); end
            else if (rd_valid) begin sc++; nv = (sc >= stall); end
            else nv = (stall == 0);
            @(posedge clk); #1;
            rd_ready = nv;
         end
      end
      if (!fin) check("rd_done_timeout", 64'd0, 64'd1);
      rd_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic clr_counts;
      en_cnt = 0; wr_cnt = 0; done_cnt = 0;
   endtask

   task automatic check_reset_outs(input string name);
      check(name, 64'({cmd_ready, wr_ready, rd_valid, head, chain_en, busy, done}), 64'b1000000);
      check({name, "_rd_data"}, 64'(rd_data), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit x;
      rst_n = 1'b0;
      cmd_valid = 0; cmd_rd = 0; wr_data = '0; wr_valid = 0; rd_ready = 0;
      cmd_valid1 = 0; cmd_rd1 = 0; wr_data1 = '0; wr_valid1 = 0; rd_ready1 = 0;
      chain = '0; chain1 = 1'b0;
      en_cnt = 0; wr_cnt = 0; done_cnt = 0; en1_cnt = 0; done1_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Straight program
      clr_counts();
      start_cmd(1'b0, 1'b0);
      feed(16'hA5C3, 16'h0FF0, 16'hBEEF, 1'b0);
      wait_done();
      @(posedge clk); #1;
      check("prog_en_cnt", 64'(en_cnt), 64'd40);
      check("prog_wr_cnt", 64'(wr_cnt), 64'd3);
      check("prog_chain", 64'(chain), 64'h00A5C30FF0BE);
      check("prog_done_cnt", 64'(done_cnt), 64'd1);

      // Readback, consumer always ready
      clr_counts();
      exp_q.push_back(16'hA5C3); exp_q.push_back(16'h0FF0); exp_q.push_back(16'h00BE);
      readback(0);
      check("rb_en_cnt", 64'(en_cnt), 64'd40);
      check("rb_chain", 64'(chain), 64'h00A5C30FF0BE);
      check("rb_q_empty", 64'(exp_q.size()), 64'd0);

      // Throttled program, stalled readback
      clr_counts();
      start_cmd(1'b0, 1'b0);
      feed(16'h1234, 16'h5678, 16'h9ABC, 1'b1);
      wait_done();
      @(posedge clk); #1;
      check("thr_en_cnt", 64'(en_cnt), 64'd40);
      check("thr_wr_cnt", 64'(wr_cnt), 64'd3);
      check("thr_chain", 64'(chain), 64'h00123456789A);
      clr_counts();
      exp_q.push_back(16'h1234); exp_q.push_back(16'h5678); exp_q.push_back(16'h009A);
      readback(5);
      check("stall_en_cnt", 64'(en_cnt), 64'd40);
      check("stall_chain", 64'(chain), 64'h00123456789A);
      check("stall_q_empty", 64'(exp_q.size()), 64'd0);

      // Reset mid program after 20 shifts
      clr_counts();
      start_cmd(1'b0, 1'b0);
      wr_data  = 16'hFFFF;
      wr_valid = 1'b1;
      x = 1'b0;
      for (int i = 0; i < 200 && !x; i++) begin
         @(negedge clk);
         x = (en_cnt >= 20);
      end
      if (!x) check("reset_wait_timeout", 64'd0, 64'd1);
      check("pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outs("async_reset");
      wr_valid = 1'b0;
      @(posedge clk); #1;
      check_reset_outs("held_reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      clr_counts();
      start_cmd(1'b0, 1'b0);
      feed(16'hA5C3, 16'h0FF0, 16'hBEEF, 1'b0);
      wait_done();
      @(posedge clk); #1;
      check("reprog_en_cnt", 64'(en_cnt), 64'd40);
      check("reprog_chain", 64'(chain), 64'h00A5C30FF0BE);

      // cmd_valid held through a program; readback queued behind it
      clr_counts();
      start_cmd(1'b0, 1'b1);
      cmd_rd = 1'b1;
      feed(16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b0);
      exp_q.push_back(16'hDEAD); exp_q.push_back(16'hBEEF); exp_q.push_back(16'h00CA);
      rd_ready = 1'b1;
      wait_done();
      check("held_chain", 64'(chain), 64'h00DEADBEEFCA);
      check("held_en_cnt", 64'(en_cnt), 64'd40);
      @(posedge clk); #1;
      @(negedge clk);
      check("held_idle_gap", 64'({cmd_ready, busy}), 64'b10);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("held_second_start", 64'({busy, chain_en}), 64'b11);
      clr_counts();
      wait_done();
      rd_ready = 1'b0;
      @(posedge clk); #1;
      check("held_rb_q_empty", 64'(exp_q.size()), 64'd0);
      check("held_rb_chain", 64'(chain), 64'h00DEADBEEFCA);

      // Single-bit chain instance
      @(negedge clk);
      check("dut1_idle", 64'(cmd_ready1), 64'd1);
      en1_cnt = 0; done1_cnt = 0;
      @(posedge clk); #1;
      cmd_valid1 = 1'b1; cmd_rd1 = 1'b0;
      @(posedge clk); #1;
      cmd_valid1 = 1'b0;
      wr_data1 = 16'h8000; wr_valid1 = 1'b1;
      x = 1'b0;
      for (int i = 0; i < 50 && !x; i++) begin
         @(negedge clk);
         x = wr_ready1;
         @(posedge clk); #1;
      end
      if (!x) check("dut1_wr_timeout", 64'd0, 64'd1);
      wr_valid1 = 1'b0;
      x = 1'b0;
      for (int i = 0; i < 50 && !x; i++) begin @(negedge clk); x = done1; end
      if (!x) check("dut1_prog_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      check("dut1_prog_en", 64'(en1_cnt), 64'd1);
      check("dut1_chain", 64'(chain1), 64'd1);
      exp1_q.push_back(16'h0001);
      rd_ready1 = 1'b1; cmd_valid1 = 1'b1; cmd_rd1 = 1'b1;
      @(posedge clk); #1;
      cmd_valid1 = 1'b0;
      x = 1'b0;
      for (int i = 0; i < 50 && !x; i++) begin @(negedge clk); x = done1; end
      if (!x) check("dut1_rb_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      rd_ready1 = 1'b0;
      check("dut1_q_empty", 64'(exp1_q.size()), 64'd0);
      check("dut1_done_cnt", 64'(done1_cnt), 64'd2);
      check("dut1_rb_en", 64'(en1_cnt), 64'd2);
      check("dut1_chain_kept", 64'(chain1), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
